// File: rtl/board_wb_arbiter_if.sv
// Wishbone bundle between the board-state requesters, the arbiter and the shared memory slave.
//
// Signals
//   m_cyc, m_stb, m_we     per-requester cycle / strobe / write enable (N_REQ bits)
//   m_adr, m_dat_w         packed per-requester address / write data, requester i at [i*W +: W]
//   m_ack, m_err           per-requester acknowledge / timeout error
//   m_dat_r                read data broadcast to all requesters
//   s_cyc, s_stb, s_we     muxed cycle / strobe / write enable toward the memory slave
//   s_adr, s_dat_w         muxed address / write data toward the memory slave
//   s_ack, s_dat_r         memory slave acknowledge / read data
//
// Modports
//   master  requester + memory side (drives m_* requests and the slave's s_ack/s_dat_r)
//   slave   arbiter side (receives requests, drives the slave port and the responses)
interface board_wb_arbiter_if #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned AW    = 12,
  parameter int unsigned DW    = 8
) ();

  logic [N_REQ-1:0]    m_cyc;
  logic [N_REQ-1:0]    m_stb;
  logic [N_REQ-1:0]    m_we;
  logic [N_REQ*AW-1:0] m_adr;
  logic [N_REQ*DW-1:0] m_dat_w;
  logic [N_REQ-1:0]    m_ack;
  logic [N_REQ-1:0]    m_err;
  logic [DW-1:0]       m_dat_r;

  logic                s_cyc;
  logic                s_stb;
  logic                s_we;
  logic [AW-1:0]       s_adr;
  logic [DW-1:0]       s_dat_w;
  logic                s_ack;
  logic [DW-1:0]       s_dat_r;

  modport master (
    output m_cyc, m_stb, m_we, m_adr, m_dat_w,
    input  m_ack, m_err, m_dat_r,
    input  s_cyc, s_stb, s_we, s_adr, s_dat_w,
    output s_ack, s_dat_r
  );

  modport slave (
    input  m_cyc, m_stb, m_we, m_adr, m_dat_w,
    output m_ack, m_err, m_dat_r,
    output s_cyc, s_stb, s_we, s_adr, s_dat_w,
    input  s_ack, s_dat_r
  );

endinterface

// File: rtl/board_wb_arbiter.sv
// Shares the board-state memory Wishbone slave between the VGA (0), defuser (1) and planter (2)
// masters. One requester owns the slave at a time; its cycle is muxed onto the slave port and
// ack/err are routed back to it only. A strobe left unacknowledged for TIMEOUT-1 cycles is
// aborted with a one-cycle m_err pulse.
//
// Ports
//   clk    system clock
//   rst    asynchronous, active-high reset
//   bus    board_wb_arbiter_if.slave: requester side (m_*) and memory slave side (s_*)
//   grant  registered one-hot owner, 0 when idle (debug / LEDs)
//
// Configuration
//   BOARD_ARB_ROUND_ROBIN_EN  defined: round-robin, search starts after the last granted index.
//                             undefined: fixed priority, lowest index (VGA) wins.
module board_wb_arbiter #(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned AW      = 12,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  board_wb_arbiter_if.slave bus,
  output logic [N_REQ-1:0]  grant
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StOwn, StAbort} state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [TW-1:0]    tmo_q, tmo_d;

  logic [N_REQ-1:0] win;
  logic             cyc_g, stb_g, we_g;
  logic [AW-1:0]    adr_g;
  logic [DW-1:0]    dat_g;
  logic             tmo_hit;

  // Isolate the lowest set bit.
  function automatic logic [N_REQ-1:0] lowest(input logic [N_REQ-1:0] req);
    return req & (~req + N_REQ'(1));
  endfunction

  // Fields of the current owner, AND-OR muxed from the one-hot grant.
  assign cyc_g = |(bus.m_cyc & grant_q);
  assign stb_g = |(bus.m_stb & grant_q);
  assign we_g  = |(bus.m_we & grant_q);

  always_comb begin
    adr_g = '0;
    dat_g = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        adr_g = adr_g | bus.m_adr[i*AW +: AW];
        dat_g = dat_g | bus.m_dat_w[i*DW +: DW];
      end
    end
  end

  // Abort fires on the strobe cycle the counter reaches TIMEOUT-1; a coincident ack wins.
  assign tmo_hit = (state_q == StOwn) && cyc_g && stb_g && !bus.s_ack &&
                   (tmo_q == TW'(TIMEOUT - 1));

`ifdef BOARD_ARB_ROUND_ROBIN_EN
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0] upper;
  logic [PW-1:0]    win_idx;

  // Requests strictly above the last granted index get first pick; otherwise wrap to 0.
  always_comb begin
    upper = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      upper[i] = bus.m_cyc[i] && (PW'(i) > ptr_q);
    end
    win = (|upper) ? lowest(upper) : lowest(bus.m_cyc);
  end

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win[i]) begin
        win_idx = PW'(i);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if ((state_q == StIdle) && (|bus.m_cyc)) begin
      ptr_d = win_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign win = lowest(bus.m_cyc);
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    tmo_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (|bus.m_cyc) begin
          grant_d = win;
          state_d = StOwn;
        end
      end
      StOwn: begin
        // Ownership is locked until the owner drops cyc; dropping mid-strobe abandons it.
        if (!cyc_g) begin
          state_d = StIdle;
          grant_d = '0;
        end else if (tmo_hit) begin
          state_d = StAbort;
        end else if (stb_g && !bus.s_ack) begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StAbort: begin
        if (!cyc_g) begin
          state_d = StIdle;
          grant_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  // Outputs: the slave port only carries the owner's cycle while in StOwn.
  always_comb begin
    bus.s_cyc   = 1'b0;
    bus.s_stb   = 1'b0;
    bus.s_we    = 1'b0;
    bus.s_adr   = '0;
    bus.s_dat_w = '0;
    bus.m_ack   = '0;
    bus.m_err   = '0;
    bus.m_dat_r = bus.s_dat_r;
    if (state_q == StOwn) begin
      bus.s_cyc   = cyc_g;
      bus.s_stb   = cyc_g && stb_g;
      bus.s_we    = we_g;
      bus.s_adr   = adr_g;
      bus.s_dat_w = dat_g;
      bus.m_ack   = grant_q & {N_REQ{cyc_g && bus.s_ack}};
      bus.m_err   = grant_q & {N_REQ{tmo_hit}};
    end
  end

  assign grant = grant_q;

endmodule

// File: tb/tb_board_wb_arbiter.sv
// Directed bench for board_wb_arbiter (N_REQ=3, AW=12, DW=8, TIMEOUT=16).
module tb_board_wb_arbiter;

  logic       clk;
  logic       rst;
  logic [2:0] grant;

  int unsigned n_cmp;
  int unsigned n_err;

  board_wb_arbiter_if #(.N_REQ(3), .AW(12), .DW(8)) bus ();

  board_wb_arbiter #(
    .N_REQ  (3),
    .AW     (12),
    .DW     (8),
    .TIMEOUT(16)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .grant(grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven 1 time unit after the rising edge; checks run after settle().
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Called just after the edge that registered grant g; completes one read and the dead cycle.
  task automatic serve(input string tag, input logic [2:0] g, input logic [11:0] adr);
    settle();
    check({tag, "_grant"}, grant, g);
    check({tag, "_adr"}, bus.s_adr, adr);
    check({tag, "_stb"}, bus.s_stb, 1);
    bus.s_ack = 1'b1;
    settle();
    check({tag, "_ack"}, bus.m_ack, g);
    cyc();
    bus.s_ack = 1'b0;
    bus.m_cyc = bus.m_cyc & ~g;
    bus.m_stb = bus.m_stb & ~g;
    cyc();
    settle();
    check({tag, "_dead_grant"}, grant, 0);
    check({tag, "_dead_cyc"}, bus.s_cyc, 0);
    cyc();
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst         = 1'b1;
    bus.m_cyc   = '0;
    bus.m_stb   = '0;
    bus.m_we    = '0;
    bus.m_adr   = '0;
    bus.m_dat_w = '0;
    bus.s_ack   = 1'b0;
    bus.s_dat_r = 8'hA5;

    // Reset values.
    cyc();
    cyc();
    settle();
    check("rst_grant", grant, 0);
    check("rst_cyc", bus.s_cyc, 0);
    check("rst_stb", bus.s_stb, 0);
    check("rst_ack", bus.m_ack, 0);
    check("rst_err", bus.m_err, 0);
    check("rst_dat_r", bus.m_dat_r, 8'hA5);
    cyc();
    rst = 1'b0;
    cyc();

    // 1: single VGA read, ack two cycles into the strobe.
    bus.m_cyc       = 3'b001;
    bus.m_stb       = 3'b001;
    bus.m_adr[11:0] = 12'h010;
    settle();
    check("t1_lat_grant", grant, 0);
    check("t1_lat_cyc", bus.s_cyc, 0);
    cyc();
    settle();
    check("t1_grant", grant, 3'b001);
    check("t1_cyc", bus.s_cyc, 1);
    check("t1_stb", bus.s_stb, 1);
    check("t1_adr", bus.s_adr, 12'h010);
    check("t1_we", bus.s_we, 0);
    check("t1_noack", bus.m_ack, 0);
    cyc();
    settle();
    check("t1_wait", bus.m_ack, 0);
    cyc();
    bus.s_ack   = 1'b1;
    bus.s_dat_r = 8'h5A;
    settle();
    check("t1_ack", bus.m_ack, 3'b001);
    check("t1_dat_r", bus.m_dat_r, 8'h5A);
    check("t1_err", bus.m_err, 0);
    cyc();
    bus.s_ack = 1'b0;
    bus.m_cyc = 3'b000;
    bus.m_stb = 3'b000;
    settle();
    check("t1_ack_drop", bus.m_ack, 0);
    check("t1_hold_grant", grant, 3'b001);
    check("t1_cyc_drop", bus.s_cyc, 0);
    cyc();
    settle();
    check("t1_idle_grant", grant, 0);

    // 2: all three request together.
    bus.m_cyc = 3'b111;
    bus.m_stb = 3'b111;
    bus.m_adr = {12'h300, 12'h200, 12'h100};
    cyc();
`ifdef BOARD_ARB_ROUND_ROBIN_EN
    serve("t2a", 3'b010, 12'h200);
    serve("t2b", 3'b100, 12'h300);
    serve("t2c", 3'b001, 12'h100);
`else
    serve("t2a", 3'b001, 12'h100);
    serve("t2b", 3'b010, 12'h200);
    serve("t2c", 3'b100, 12'h300);
`endif

    // 3: locked defuser write burst while VGA waits.
    bus.m_cyc = 3'b010;
    bus.m_stb = 3'b010;
    bus.m_we  = 3'b010;
    cyc();
    bus.m_cyc       = 3'b011;
    bus.m_stb       = 3'b011;
    bus.m_adr[11:0] = 12'h0AA;
    for (int i = 0; i < 4; i++) begin
      bus.m_adr[23:12]  = 12'h020 + 12'(i);
      bus.m_dat_w[15:8] = 8'h11 + 8'(i);
      bus.s_ack         = 1'b1;
      settle();
      check("t3_grant", grant, 3'b010);
      check("t3_adr", bus.s_adr, 12'h020 + 12'(i));
      check("t3_dat_w", bus.s_dat_w, 8'h11 + 8'(i));
      check("t3_we", bus.s_we, 1);
      check("t3_ack", bus.m_ack, 3'b010);
      cyc();
    end
    bus.s_ack = 1'b0;
    bus.m_cyc = 3'b001;
    bus.m_stb = 3'b001;
    bus.m_we  = 3'b000;
    settle();
    check("t3_release_grant", grant, 3'b010);
    cyc();
    settle();
    check("t3_dead_grant", grant, 0);
    cyc();
    settle();
    check("t3_vga_grant", grant, 3'b001);
    check("t3_vga_adr", bus.s_adr, 12'h0AA);
    bus.m_cyc = 3'b000;
    bus.m_stb = 3'b000;
    cyc();
    cyc();

    // 4: planter read never acknowledged.
    bus.m_cyc        = 3'b100;
    bus.m_stb        = 3'b100;
    bus.m_adr[35:24] = 12'h3FF;
    cyc();
    for (int i = 0; i < 15; i++) begin
      settle();
      check("t4_no_err", bus.m_err, 0);
      cyc();
    end
    settle();
    check("t4_err", bus.m_err, 3'b100);
    check("t4_err_noack", bus.m_ack, 0);
    cyc();
    settle();
    check("t4_abort_cyc", bus.s_cyc, 0);
    check("t4_abort_stb", bus.s_stb, 0);
    check("t4_abort_err", bus.m_err, 0);
    check("t4_abort_grant", grant, 3'b100);
    bus.s_ack = 1'b1;
    settle();
    check("t4_abort_ack_ignored", bus.m_ack, 0);
    cyc();
    bus.s_ack = 1'b0;
    bus.m_cyc = 3'b000;
    bus.m_stb = 3'b000;
    settle();
    check("t4_abort_hold", grant, 3'b100);
    cyc();
    settle();
    check("t4_idle_grant", grant, 0);

    // 5: ack lands on the timeout cycle.
    bus.m_cyc = 3'b100;
    bus.m_stb = 3'b100;
    cyc();
    for (int i = 0; i < 15; i++) begin
      cyc();
    end
    bus.s_ack   = 1'b1;
    bus.s_dat_r = 8'h3C;
    settle();
    check("t5_ack", bus.m_ack, 3'b100);
    check("t5_no_err", bus.m_err, 0);
    check("t5_dat_r", bus.m_dat_r, 8'h3C);
    cyc();
    bus.s_ack = 1'b0;
    settle();
    check("t5_still_own", bus.s_cyc, 1);
    check("t5_grant", grant, 3'b100);
    check("t5_err_after", bus.m_err, 0);
    bus.m_cyc = 3'b000;
    bus.m_stb = 3'b000;
    cyc();
    cyc();

    // 6: asynchronous reset in the middle of a burst.
    bus.m_cyc        = 3'b010;
    bus.m_stb        = 3'b010;
    bus.m_we         = 3'b010;
    bus.m_adr[23:12] = 12'h040;
    cyc();
    bus.s_ack = 1'b1;
    settle();
    check("t6_ack", bus.m_ack, 3'b010);
    #1;
    rst = 1'b1;
    #1;
    check("t6_rst_grant", grant, 0);
    check("t6_rst_cyc", bus.s_cyc, 0);
    check("t6_rst_stb", bus.s_stb, 0);
    check("t6_rst_ack", bus.m_ack, 0);
    cyc();
    cyc();
    rst       = 1'b0;
    bus.s_ack = 1'b0;
    settle();
    check("t6_post_rst_grant", grant, 0);
    cyc();
    settle();
    check("t6_regrant", grant, 3'b010);
    check("t6_regrant_cyc", bus.s_cyc, 1);
    check("t6_regrant_adr", bus.s_adr, 12'h040);
    bus.m_cyc = 3'b000;
    bus.m_stb = 3'b000;
    bus.m_we  = 3'b000;
    cyc();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
